// File: rtl/oram_host_ingress_pkg.sv
// ----------------------------------------------------------------------------
// oram_host_ingress_pkg
//   Shared definitions for the ORAM host ingress stage:
//     - default geometry (address / block / beat / mask / command widths)
//     - first illegal program address for the optional address check
//     - command encodings and the read-class helper
//     - ingress state encodings
//     - beat-count derivation helpers
// ----------------------------------------------------------------------------
package oram_host_ingress_pkg;

    localparam int P_ORAMU      = 32;
    localparam int P_ORAMB      = 512;
    localparam int P_FEDWidth   = 64;
    localparam int P_DMWidth    = 8;
    localparam int P_BECMDWidth = 2;

    // First program address that is rejected when the address check is built in.
    localparam logic [63:0] MaxProgAddr = 64'd1 << 20;

    typedef enum logic [1:0] {
        CMD_Write   = 2'b00,
        CMD_Read    = 2'b01,
        CMD_Append  = 2'b10,
        CMD_ReadRmv = 2'b11
    } cmd_e;

    // WDROP / RZERO only become reachable when the address check is built in.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WDATA = 3'd2,
        ST_RDATA = 3'd3,
        ST_WDROP = 3'd4,
        ST_RZERO = 3'd5
    } state_e;

    function automatic int beats_of(input int block_bits, input int beat_bits);
        return block_bits / beat_bits;
    endfunction

    // A single-beat block still gets a 1-bit counter so ports never collapse to zero width.
    function automatic int beat_cnt_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    localparam int Beats = beats_of(P_ORAMB, P_FEDWidth);

    function automatic logic is_read_cmd(input logic [1:0] cmd);
        return (cmd_e'(cmd) == CMD_Read) || (cmd_e'(cmd) == CMD_ReadRmv);
    endfunction

endpackage

// File: rtl/oram_beat_counter.sv
// ----------------------------------------------------------------------------
// oram_beat_counter
//   Modulo-BEATS beat counter shared by every data state of the ingress.
//   Ports:
//     clk_i   - system clock
//     rst_i   - asynchronous active-high reset (count -> 0)
//     clr_i   - synchronous clear, wins over enable
//     en_i    - count one beat handshake
//     last_o  - current count equals BEATS-1 (the beat in flight is the last)
// ----------------------------------------------------------------------------
module oram_beat_counter #(
    parameter int BEATS = 8,
    parameter int CNT_W = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic last_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign last_o = (count_q == LAST_CNT);

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = last_o ? '0 : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/oram_host_ingress.sv
// ----------------------------------------------------------------------------
// oram_host_ingress
//   Upstream stage of the ORAM frontend. Accepts one host request at a time,
//   issues it on CmdIn/ProgAddrIn/WMaskIn, then either streams Beats write
//   beats host -> DataIn or Beats read beats ReturnData -> host. Exactly one
//   transaction is outstanding, so data streams never interleave.
//
//   Ports:
//     clk_i / rst_i                        clock, asynchronous active-high reset
//     HostCmd*_i/_o                        host command channel (valid/ready)
//     HostData*_i/_o                       host write-beat channel
//     HostResp*_i/_o                       read beats back to host
//     CmdIn*_i/_o, ProgAddrIn_o, WMaskIn_o command issue to the frontend
//     DataIn*_i/_o                         write beats to the frontend
//     ReturnData*_i/_o                     read beats from the frontend
//     Busy_o                               high whenever not idle
//     AddrError_o                          sticky illegal-address flag (only
//                                          with ORAM_INGRESS_ADDR_CHECK_EN)
//
//   Build option: define ORAM_INGRESS_ADDR_CHECK_EN to reject program
//   addresses >= MaxProgAddr. Rejected writes have their beats swallowed,
//   rejected reads return all-zero beats; nothing reaches the frontend.
// ----------------------------------------------------------------------------
module oram_host_ingress
    import oram_host_ingress_pkg::*;
#(
    parameter int ORAMU      = P_ORAMU,
    parameter int ORAMB      = P_ORAMB,
    parameter int FEDWidth   = P_FEDWidth,
    parameter int DMWidth    = P_DMWidth,
    parameter int BECMDWidth = P_BECMDWidth
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  HostCmdValid_i,
    output logic                  HostCmdReady_o,
    input  logic [BECMDWidth-1:0] HostCmd_i,
    input  logic [ORAMU-1:0]      HostAddr_i,
    input  logic [DMWidth-1:0]    HostWMask_i,

    input  logic                  HostDataValid_i,
    output logic                  HostDataReady_o,
    input  logic [FEDWidth-1:0]   HostData_i,

    output logic                  HostRespValid_o,
    input  logic                  HostRespReady_i,
    output logic [FEDWidth-1:0]   HostResp_o,

    output logic                  CmdInValid_o,
    input  logic                  CmdInReady_i,
    output logic [BECMDWidth-1:0] CmdIn_o,
    output logic [ORAMU-1:0]      ProgAddrIn_o,
    output logic [DMWidth-1:0]    WMaskIn_o,

    output logic                  DataInValid_o,
    input  logic                  DataInReady_i,
    output logic [FEDWidth-1:0]   DataIn_o,

    input  logic                  ReturnDataValid_i,
    output logic                  ReturnDataReady_o,
    input  logic [FEDWidth-1:0]   ReturnData_i,

    output logic                  Busy_o
`ifdef ORAM_INGRESS_ADDR_CHECK_EN
    ,
    output logic                  AddrError_o
`endif
);

    localparam int BEATS = beats_of(ORAMB, FEDWidth);
    localparam int CNT_W = beat_cnt_width(BEATS);

    state_e                  state_q;
    logic [BECMDWidth-1:0]   cmd_q;
    logic [ORAMU-1:0]        addr_q;
    logic [DMWidth-1:0]      wmask_q;
    logic                    cmd_valid_q;
    logic                    host_cmd_ready_q;

    logic                    beat_hs;
    logic                    beat_last;
    logic                    addr_illegal;

`ifdef ORAM_INGRESS_ADDR_CHECK_EN
    logic                    addr_err_q;
    assign addr_illegal = (64'(HostAddr_i) >= MaxProgAddr);
    assign AddrError_o  = addr_err_q;
`else
    assign addr_illegal = 1'b0;
`endif

    // One beat completes in whichever data state owns the stream.
    always_comb begin
        beat_hs = 1'b0;
        case (state_q)
            ST_WDATA: beat_hs = HostDataValid_i && DataInReady_i;
            ST_RDATA: beat_hs = ReturnDataValid_i && HostRespReady_i;
`ifdef ORAM_INGRESS_ADDR_CHECK_EN
            ST_WDROP: beat_hs = HostDataValid_i;
            ST_RZERO: beat_hs = HostRespReady_i;
`endif
            default:  beat_hs = 1'b0;
        endcase
    end

    // Held clear while idle so every transaction starts counting from zero.
    oram_beat_counter #(
        .BEATS (BEATS),
        .CNT_W (CNT_W)
    ) u_beat_counter (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (state_q == ST_IDLE),
        .en_i   (beat_hs),
        .last_o (beat_last)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q          <= ST_IDLE;
            cmd_q            <= '0;
            addr_q           <= '0;
            wmask_q          <= '0;
            cmd_valid_q      <= 1'b0;
            host_cmd_ready_q <= 1'b1;
`ifdef ORAM_INGRESS_ADDR_CHECK_EN
            addr_err_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (HostCmdValid_i && host_cmd_ready_q) begin
                        cmd_q            <= HostCmd_i;
                        addr_q           <= HostAddr_i;
                        wmask_q          <= HostWMask_i;
                        host_cmd_ready_q <= 1'b0;
                        if (addr_illegal) begin
                            // Skip issue entirely; the host still sees a full-length stream.
                            state_q <= is_read_cmd(HostCmd_i) ? ST_RZERO : ST_WDROP;
`ifdef ORAM_INGRESS_ADDR_CHECK_EN
                            addr_err_q <= 1'b1;
`endif
                        end else begin
                            state_q     <= ST_ISSUE;
                            cmd_valid_q <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (CmdInReady_i) begin
                        cmd_valid_q <= 1'b0;
                        state_q     <= is_read_cmd(cmd_q) ? ST_RDATA : ST_WDATA;
                    end
                end
                ST_WDATA, ST_RDATA, ST_WDROP, ST_RZERO: begin
                    if (beat_hs && beat_last) begin
                        state_q          <= ST_IDLE;
                        host_cmd_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q          <= ST_IDLE;
                    cmd_valid_q      <= 1'b0;
                    host_cmd_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign HostCmdReady_o = host_cmd_ready_q;
    assign CmdInValid_o   = cmd_valid_q;
    assign CmdIn_o        = cmd_q;
    assign ProgAddrIn_o   = addr_q;
    assign WMaskIn_o      = wmask_q;
    assign Busy_o         = (state_q != ST_IDLE);

    // Data channels are pure pass-through, gated to their owning state.
    assign DataInValid_o     = (state_q == ST_WDATA) && HostDataValid_i;
    assign DataIn_o          = HostData_i;
    assign HostDataReady_o   = ((state_q == ST_WDATA) && DataInReady_i) || (state_q == ST_WDROP);

    assign HostRespValid_o   = ((state_q == ST_RDATA) && ReturnDataValid_i) || (state_q == ST_RZERO);
    assign HostResp_o        = (state_q == ST_RDATA) ? ReturnData_i : '0;
    assign ReturnDataReady_o = (state_q == ST_RDATA) && HostRespReady_i;

endmodule

// File: doc/oram_host_ingress.md
Name: oram_host_ingress

Overview:
- Upstream stage of the ORAM frontend. Accepts host memory requests: command, program address, write mask and a beat-serialized data block.
- Issues exactly one command at a time into the frontend's CmdIn/ProgAddrIn/WMaskIn port, then streams write beats into DataIn or collects ReturnData beats back to the host.
- Enforces strict one-outstanding ordering, so the frontend never sees interleaved data streams.

Parameters:
- ORAMU, 32, program address width
- ORAMB, 512, block size in bits
- FEDWidth, 64, data beat width; ORAMB must be an integer multiple
- DMWidth, 8, write mask width
- BECMDWidth, 2, command width
- MaxProgAddr, 2**20, first illegal program address (used by the optional feature)

Ports:
- Clock  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- HostCmdValid  in  1  host command valid
- HostCmdReady  out  1  host command accepted
- HostCmd  in  BECMDWidth  host command
- HostAddr  in  ORAMU  host program address
- HostWMask  in  DMWidth  host write mask
- HostDataValid  in  1  host write-beat valid
- HostDataReady  out  1  host write beat accepted
- HostData  in  FEDWidth  host write beat
- HostRespValid  out  1  read beat to host valid
- HostRespReady  in  1  host accepts read beat
- HostResp  out  FEDWidth  read beat to host
- CmdInValid  out  1  command to frontend valid
- CmdInReady  in  1  frontend accepts command
- CmdIn  out  BECMDWidth  command to frontend
- ProgAddrIn  out  ORAMU  address to frontend
- WMaskIn  out  DMWidth  mask to frontend
- DataInValid  out  1  write beat to frontend valid
- DataInReady  in  1  frontend accepts write beat
- DataIn  out  FEDWidth  write beat to frontend
- ReturnDataValid  in  1  read beat from frontend valid
- ReturnDataReady  out  1  ingress accepts read beat
- ReturnData  in  FEDWidth  read beat from frontend
- Busy  out  1  high whenever state is not IDLE

Behaviour:
- Beats = ORAMB/FEDWidth.
- Beat counter is clog2(Beats) bits; it clears on every entry to IDLE.
- Command classes:
  - CMD_Write and CMD_Append are write-class.
  - CMD_Read and CMD_ReadRmv are read-class.
- State IDLE:
  - HostCmdReady = 1.
  - On HostCmdValid&&HostCmdReady, register {HostCmd, HostAddr, HostWMask} and go to ISSUE.
- State ISSUE:
  - CmdInValid = 1, driven from the registered values, which are held stable until the handshake.
  - On CmdInReady, a write-class command goes to WDATA and a read-class command goes to RDATA.
  - Host-to-CmdIn latency is 1 cycle minimum.
- State WDATA:
  - Combinational pass-through: DataInValid = HostDataValid, HostDataReady = DataInReady, DataIn = HostData.
  - Counter increments per handshake.
  - A handshake with counter == Beats-1 returns to IDLE.
- State RDATA:
  - Combinational pass-through: HostRespValid = ReturnDataValid, ReturnDataReady = HostRespReady, HostResp = ReturnData.
  - The last beat (counter == Beats-1) returns to IDLE.
- Outside their owning state, HostDataReady, DataInValid, HostRespValid and ReturnDataReady are 0.
- Back-pressure and stalls:
  - Holding a ready low stalls the data stream indefinitely with no beat loss.
  - A host beat presented early in IDLE or ISSUE is not accepted.
- A new command is accepted only in IDLE, i.e. the cycle after the last beat completes. Back-to-back throughput is therefore 1 + 1 + Beats cycles minimum.
- Reset:
  - State = IDLE, counter = 0, registered command fields = 0.
  - All valid/ready outputs = 0 except HostCmdReady = 1. Busy = 0.
  - Reset mid-transaction abandons it immediately with no cleanup beats.

Optional Feature:
- Macro: ORAM_INGRESS_ADDR_CHECK_EN
- Enabled:
  - In IDLE, HostAddr >= MaxProgAddr marks the transaction illegal. No CmdIn is issued; ISSUE is skipped.
  - Illegal write: go to WDATA-DROP, accept and discard Beats host beats (HostDataReady = 1).
  - Illegal read: go to RDATA-ZERO, present Beats all-zero beats on HostResp with HostRespValid = 1.
  - Sticky output AddrError (1 bit, reset 0) is set.
- Disabled: no check is performed, the AddrError port is absent, and every address is forwarded.

Decomposition:
- Shared package holds:
  - command encodings: CMD_Write = 2'b00, CMD_Read = 2'b01, CMD_Append = 2'b10, CMD_ReadRmv = 2'b11
  - an is-read-class helper
  - state encodings
  - the Beats localparam derivation
- One natural sub-module, oram_beat_counter: a Beats-modulo counter with clear, enable and a last flag, reused by both data states.

Test Plan:
- Write, Beats = 8, addr 0x100, beats 0..7, both readies high → CmdIn = 00 / addr 0x100 one cycle after accept; DataIn beats 0..7 in order; Busy low on the cycle after beat 7.
- Read, addr 0x2A, ReturnData 0xA0..0xA7 with HostRespReady toggled every cycle → HostResp delivers 0xA0..0xA7 exactly once each; no ReturnDataReady while HostRespReady = 0.
- CmdInReady held low 5 cycles during ISSUE → CmdIn/ProgAddrIn/WMaskIn remain stable; second HostCmdValid not accepted (HostCmdReady = 0).
- Reset asserted after write beat 3 → all valids drop asynchronously; state returns to IDLE; next read issues correctly with counter starting at 0.
- Host data presented during IDLE/ISSUE → HostDataReady = 0; the first beat transfers only after the CmdIn handshake.
- With ORAM_INGRESS_ADDR_CHECK_EN: read at MaxProgAddr → no CmdInValid, eight zero beats, AddrError = 1; a subsequent legal write proceeds normally and AddrError stays 1.
